// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl
//   Single-byte I2C master. One accepted request runs a complete bus
//   transaction: START, 7-bit address + R/W, address ACK, one data byte,
//   data ACK/NACK, STOP. An address NACK skips the data phase and goes
//   straight to STOP.
//
//   Each bus bit is four quarters (Q0..Q3) of CLK_DIV system clocks each:
//   SCL is low in Q0/Q1 and high in Q2/Q3. SDA changes on entry to Q0 and
//   is sampled on the last clock of Q2.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   start             request, sampled only while idle
//   addr, wr_en       slave address; 1 = write data_in, 0 = read
//   data_in           byte to write
//   data_out          last byte read (updated with done on a read)
//   busy, done        transaction in progress / one-cycle completion pulse
//   ack_err           sticky NACK flag, cleared by the next accepted start
//   scl               SCL level
//   sda_out, sda_oe   SDA value and drive enable (0 = released, bus high)
//   sda_in            sampled SDA bus level
module i2c_master_byte_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_out,
  output logic       sda_oe,
  input  logic       sda_in
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    DATA,
    DACK,
    STOP
  } state_t;

  localparam int             QW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0]  QMAX = QW'(CLK_DIV - 1);

  state_t          state, state_d;
  logic [QW-1:0]   qcnt;
  logic [1:0]      q;
  logic [2:0]      bitc;
  logic [7:0]      addr_byte;
  logic [7:0]      wdata;
  logic            wr;
  logic            nack;
  logic [7:0]      rd_shift;

  logic            qend;
  logic            bit_end;
  logic            samp;

  assign qend    = (qcnt == QMAX);
  assign bit_end = qend && (q == 2'd3);
  // Last system clock of Q2: SCL has been high for a full quarter.
  assign samp    = qend && (q == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      qcnt      <= '0;
      q         <= 2'd0;
      bitc      <= 3'd0;
      addr_byte <= 8'h00;
      wdata     <= 8'h00;
      wr        <= 1'b0;
      nack      <= 1'b0;
      rd_shift  <= 8'h00;
      ack_err   <= 1'b0;
      done      <= 1'b0;
      data_out  <= 8'h00;
    end else begin
      state <= state_d;
      done  <= 1'b0;

      if (state == IDLE) begin
        qcnt <= '0;
        q    <= 2'd0;
        bitc <= 3'd0;
        if (start) begin
          // Request is captured here so the host may change inputs afterwards.
          addr_byte <= {addr, ~wr_en};
          wdata     <= data_in;
          wr        <= wr_en;
          nack      <= 1'b0;
          ack_err   <= 1'b0;
        end
      end else begin
        if (qend) begin
          qcnt <= '0;
          q    <= q + 2'd1;
        end else begin
          qcnt <= qcnt + QW'(1);
        end

        // Bit counter only advances inside the 8-bit phases; 7 wraps to 0
        // exactly as the FSM moves on to the ACK slot.
        if (bit_end && (state == ADDR || state == DATA))
          bitc <= bitc + 3'd1;

        if (samp) begin
          case (state)
            AACK: begin
              nack <= sda_in;
              if (sda_in) ack_err <= 1'b1;
            end
            DATA: if (!wr) rd_shift <= {rd_shift[6:0], sda_in};
            DACK: if (wr && sda_in) ack_err <= 1'b1;
            default: ;
          endcase
        end

        if (state == STOP && bit_end) begin
          done <= 1'b1;
          if (!wr) data_out <= rd_shift;
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    busy    = (state != IDLE);
    scl     = 1'b1;
    sda_out = 1'b1;
    sda_oe  = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_d = START;
      end
      START: begin
        // SDA falls in Q2 while SCL is still high, then SCL drops in Q3.
        sda_oe  = 1'b1;
        sda_out = (q < 2'd2);
        scl     = (q != 2'd3);
        if (bit_end) state_d = ADDR;
      end
      ADDR: begin
        scl     = q[1];
        sda_oe  = 1'b1;
        sda_out = addr_byte[~bitc];
        if (bit_end && bitc == 3'd7) state_d = AACK;
      end
      AACK: begin
        scl = q[1];
        if (bit_end) state_d = nack ? STOP : DATA;
      end
      DATA: begin
        scl     = q[1];
        sda_oe  = wr;
        sda_out = wr ? wdata[~bitc] : 1'b1;
        if (bit_end && bitc == 3'd7) state_d = DACK;
      end
      DACK: begin
        // Write: release for the slave ACK. Read: master NACKs the single byte.
        scl     = q[1];
        sda_oe  = ~wr;
        sda_out = 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // SDA held low until SCL is high, then released in Q3.
        scl     = q[1];
        sda_oe  = (q != 2'd3);
        sda_out = 1'b0;
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
